// File: rtl/rom_bus_ctrl_if.sv
// CPU/ROM bus bundle for rom_bus_ctrl: the CPU request handshake plus the boot ROM
// select/address/data lines. The slave modport is the controller's view.
interface rom_bus_ctrl_if;
  logic        req;
  logic [15:0] addr;
  logic        rnw;
  logic [7:0]  rdata;
  logic        ready;
  logic        err;
  logic        mem_sel;
  logic [3:0]  mem_a;
  logic [7:0]  mem_din;

  modport slave (
    input  req, addr, rnw, mem_din,
    output rdata, ready, err, mem_sel, mem_a
  );

  modport master (
    output req, addr, rnw, mem_din,
    input  rdata, ready, err, mem_sel, mem_a
  );
endinterface

// File: rtl/rom_bus_ctrl.sv
// Bus controller in front of the 16-byte async boot ROM: decodes the vector window,
// runs a wait-stated ROM read, and answers unmapped reads and writes locally.
// Optional last-hit cache of one ROM byte: define ROM_BUS_LASTHIT_EN.
module rom_bus_ctrl #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] ROM_BASE    = 16'hFFF0,
  parameter logic [7:0]  OPEN_BUS    = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  rom_bus_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic       sel_q, sel_d;
  logic [3:0] a_q, a_d;
  logic       rom_hit;

`ifdef ROM_BUS_LASTHIT_EN
  logic       lh_valid_q, lh_valid_d;
  logic [3:0] lh_tag_q, lh_tag_d;
  logic [7:0] lh_data_q, lh_data_d;
  logic       lh_match;

  assign lh_match = lh_valid_q && (lh_tag_q == bus.addr[3:0]);
`endif

  assign rom_hit = (bus.addr & 16'hFFF0) == ROM_BASE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The request is only looked at in IDLE, so addr/rnw wiggles during an access are harmless.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = err_q;
    sel_d   = sel_q;
    a_d     = a_q;
`ifdef ROM_BUS_LASTHIT_EN
    lh_valid_d = lh_valid_q;
    lh_tag_d   = lh_tag_q;
    lh_data_d  = lh_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (!bus.rnw) begin
            rdata_d = OPEN_BUS;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = DONE;
          end else if (!rom_hit) begin
            rdata_d = OPEN_BUS;
            err_d   = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
`ifdef ROM_BUS_LASTHIT_EN
          end else if (lh_match) begin
            rdata_d = lh_data_q;
            err_d   = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
`endif
          end else begin
            sel_d   = 1'b1;
            a_d     = bus.addr[3:0];
            cnt_d   = WAIT_INIT;
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = bus.mem_din;
          sel_d   = 1'b0;
          err_d   = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
`ifdef ROM_BUS_LASTHIT_EN
          lh_valid_d = 1'b1;
          lh_tag_d   = a_q;
          lh_data_d  = bus.mem_din;
`endif
        end
      end

      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        sel_d   = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Every bus-visible output is a flop so the ROM sees glitch-free select and address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      rdata_q <= 8'h00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      a_q     <= 4'h0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
    end
  end

`ifdef ROM_BUS_LASTHIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lh_valid_q <= 1'b0;
      lh_tag_q   <= 4'h0;
      lh_data_q  <= 8'h00;
    end else begin
      lh_valid_q <= lh_valid_d;
      lh_tag_q   <= lh_tag_d;
      lh_data_q  <= lh_data_d;
    end
  end
`endif

  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.mem_sel = sel_q;
  assign bus.mem_a   = a_q;

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Scoreboard bench for rom_bus_ctrl: two instances (WAIT_STATES=2 and 0) share one ROM image;
// the driver queues expected responses and a per-instance monitor checks each ready pulse.
module tb_rom_bus_ctrl;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       err;
    int         rcyc;
    int         selc;
    logic [3:0] off;
  } exp_t;

`ifdef ROM_BUS_LASTHIT_EN
  localparam int HIT_LAT = 0;
  localparam int HIT_SEL = 0;
`else
  localparam int HIT_LAT = 3;
  localparam int HIT_SEL = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  logic        req[2];
  logic [15:0] addr[2];
  logic        rnw[2];
  logic        rdy[2];
  logic        errv[2];
  logic        selv[2];
  logic [3:0]  av[2];
  logic [7:0]  rdv[2];
  int          sel_cnt[2];
  logic        a_bad[2];
  logic [7:0]  rom[16];

  rom_bus_ctrl_if bus2();
  rom_bus_ctrl_if bus0();

  rom_bus_ctrl #(.WAIT_STATES(2)) dut  (.clk(clk), .reset(rst), .bus(bus2.slave));
  rom_bus_ctrl #(.WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0.slave));

  assign bus2.req     = req[0];
  assign bus2.addr    = addr[0];
  assign bus2.rnw     = rnw[0];
  assign bus2.mem_din = rom[bus2.mem_a];
  assign bus0.req     = req[1];
  assign bus0.addr    = addr[1];
  assign bus0.rnw     = rnw[1];
  assign bus0.mem_din = rom[bus0.mem_a];

  assign rdy[0]  = bus2.ready;
  assign errv[0] = bus2.err;
  assign selv[0] = bus2.mem_sel;
  assign av[0]   = bus2.mem_a;
  assign rdv[0]  = bus2.rdata;
  assign rdy[1]  = bus0.ready;
  assign errv[1] = bus0.err;
  assign selv[1] = bus0.mem_sel;
  assign av[1]   = bus0.mem_a;
  assign rdv[1]  = bus0.rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request, queue its expected response, and hold req until ready (bounded).
  task automatic applyStimulus(input int g, input logic [15:0] a, input logic r,
                               input logic [7:0] d, input logic e, input int lat, input int selc);
    exp_t x;
    bit   seen;
    @(negedge clk);
    x = '{dut: g, data: d, err: e, rcyc: cyc + 1 + lat, selc: selc, off: a[3:0]};
    sbq.push_back(x);
    req[g]  = 1'b1;
    addr[g] = a;
    rnw[g]  = r;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rdy[g]) seen = 1'b1;
      else begin
        addr[g] = ~a;
        rnw[g]  = ~r;
      end
    end
    req[g] = 1'b0;
    checkOutput("ready_seen", int'(seen), 1);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t x;
      if (rst) begin
        sel_cnt[g] = 0;
        a_bad[g]   = 1'b0;
      end else begin
        if (selv[g]) begin
          sel_cnt[g]++;
          if (sbq.size() > 0 && av[g] != sbq[0].off) a_bad[g] = 1'b1;
        end
        if (rdy[g]) begin
          if (sbq.size() == 0) begin
            checkOutput("unexpected_ready", 1, 0);
          end else begin
            x = sbq.pop_front();
            checkOutput("dut_index", g, x.dut);
            checkOutput("rdata", int'(rdv[g]), int'(x.data));
            checkOutput("err", int'(errv[g]), int'(x.err));
            checkOutput("ready_cycle", cyc, x.rcyc);
            checkOutput("mem_sel_cycles", sel_cnt[g], x.selc);
            checkOutput("mem_a_stable", int'(a_bad[g]), 0);
          end
          sel_cnt[g] = 0;
          a_bad[g]   = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'(16 * i + 3);
    rom[0]  = 8'h4F;
    rom[1]  = 8'h4C;
    rom[14] = 8'hFF;
    for (int g = 0; g < 2; g++) begin
      req[g]     = 1'b0;
      addr[g]    = 16'h0000;
      rnw[g]     = 1'b1;
      sel_cnt[g] = 0;
      a_bad[g]   = 1'b0;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", int'(bus2.rdata), 8'h00);
    checkOutput("reset_ready", int'(bus2.ready), 0);
    checkOutput("reset_err", int'(bus2.err), 0);
    checkOutput("reset_mem_sel", int'(bus2.mem_sel), 0);
    checkOutput("reset_mem_a", int'(bus2.mem_a), 0);
    rst = 1'b0;

    applyStimulus(0, 16'hFFF0, 1'b1, 8'h4F, 1'b0, 3, 3);
    applyStimulus(1, 16'hFFFE, 1'b1, 8'hFF, 1'b0, 1, 1);
    applyStimulus(0, 16'h1234, 1'b1, 8'hFF, 1'b0, 0, 0);
    applyStimulus(0, 16'hFFF3, 1'b0, 8'hFF, 1'b1, 0, 0);
    applyStimulus(1, 16'h0007, 1'b0, 8'hFF, 1'b1, 0, 0);

    // Abort a mapped read one cycle after it is accepted.
    @(negedge clk);
    req[0]  = 1'b1;
    addr[0] = 16'hFFF0;
    rnw[0]  = 1'b1;
    @(negedge clk);
    rst    = 1'b1;
    req[0] = 1'b0;
    #1;
    checkOutput("abort_mem_sel", int'(bus2.mem_sel), 0);
    checkOutput("abort_ready", int'(bus2.ready), 0);
    checkOutput("abort_rdata", int'(bus2.rdata), 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 16'hFFF2, 1'b1, 8'h23, 1'b0, 3, 3);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rdata_hold", int'(bus2.rdata), 8'h23);
    end
    applyStimulus(0, 16'hFFF1, 1'b1, 8'h4C, 1'b0, 3, 3);
    applyStimulus(0, 16'hFFF1, 1'b1, 8'h4C, 1'b0, HIT_LAT, HIT_SEL);
    applyStimulus(0, 16'hFFF1, 1'b0, 8'hFF, 1'b1, 0, 0);
    applyStimulus(0, 16'hFFF1, 1'b1, 8'h4C, 1'b0, HIT_LAT, HIT_SEL);
    applyStimulus(0, 16'hFFF0, 1'b1, 8'h4F, 1'b0, 3, 3);
    applyStimulus(1, 16'hFFF5, 1'b1, 8'h53, 1'b0, 1, 1);

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
